// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - handshaked ALU + iterative RV-M multiply/divide (optional ALU_FAST_MUL_EN single-cycle multiply)
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_n, entry_state;

  // operand decode
  logic            is_mul, is_div, a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic            accept, direct;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, spec_res, fast_res, direct_res;

  // latched operation for the iterative engine
  logic [4:0]      op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] mag_a_q, mag_b_q;
  logic [XLEN-1:0] acc_hi, acc_lo;
  logic [SHW-1:0]  cnt;

  // per-iteration step and final sign correction
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
  logic [2*XLEN-1:0] mul_full, mul_signed;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_sh;
  logic              div_ok;
  logic [XLEN-1:0]   div_hi_n, div_lo_n, div_quo, div_rem, div_res;

  // classify the incoming op and form operand magnitudes for the iterative engine
  always_comb begin
    is_mul   = (op >= OP_MUL) && (op <= OP_MULHU);
    is_div   = (op >= OP_DIV) && (op <= OP_REMU);
    a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa       = a_sgn & a[XLEN-1];
    sb       = b_sgn & b[XLEN-1];
    mag_a    = sa ? (~a + 1'b1) : a;
    mag_b    = sb ? (~b + 1'b1) : b;
    div_zero = (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == '1);
  end

`ifdef ALU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*XLEN-1:0] fm_a, fm_b, fm_p;

  // whole product in one cycle; sign/zero extension to 2*XLEN makes one multiplier serve all variants
  always_comb begin
    fm_a     = a_sgn ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    fm_b     = b_sgn ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    fm_p     = fm_a * fm_b;
    fast_res = (op == OP_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
  end
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_res = '0;
`endif

  // single-cycle base ALU; unknown op codes fall through to ADD
  always_comb begin
    shamt   = b[SHW-1:0];
    alu_res = a + b;
    case (op)
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_res = a + b;
    endcase
  end

  // pick the result for ops that complete at the accept edge and where they go next
  always_comb begin
    if (div_zero) begin
      spec_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
    end else begin
      spec_res = (op == OP_DIV) ? MIN_VAL : '0;
    end
    direct = (!is_mul && !is_div) || (is_mul && FAST_MUL) || (is_div && (div_zero || div_ovf));
    if (is_div) begin
      direct_res = spec_res;
    end else if (is_mul) begin
      direct_res = fast_res;
    end else begin
      direct_res = alu_res;
    end
    if (direct) begin
      entry_state = S_DONE;
    end else if (is_mul) begin
      entry_state = S_MUL;
    end else begin
      entry_state = S_DIV;
    end
  end

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL) || (state == S_DIV);

  // one shift-add step and one restoring-divide step, plus the sign-corrected final values
  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});
    mul_hi_n   = mul_sum[XLEN:1];
    mul_lo_n   = {mul_sum[0], acc_lo[XLEN-1:1]};
    mul_full   = {mul_hi_n, mul_lo_n};
    mul_signed = (sa_q ^ sb_q) ? (~mul_full + 1'b1) : mul_full;
    mul_res    = (op_q == OP_MUL) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];

    div_sh     = {acc_hi, acc_lo[XLEN-1]};
    div_ok     = (div_sh >= {1'b0, mag_b_q});
    // the true difference is below 2^XLEN whenever div_ok, so the low bits are exact
    div_hi_n   = div_ok ? (div_sh[XLEN-1:0] - mag_b_q) : div_sh[XLEN-1:0];
    div_lo_n   = {acc_lo[XLEN-2:0], div_ok};
    div_quo    = (sa_q ^ sb_q) ? (~div_lo_n + 1'b1) : div_lo_n;
    div_rem    = sa_q ? (~div_hi_n + 1'b1) : div_hi_n;
    div_res    = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? div_quo : div_rem;
  end

  // next-state: flush overrides everything, including a same-cycle accept
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = entry_state;
      S_MUL:  if (cnt == '0) state_n = S_DONE;
      S_DIV:  if (cnt == '0) state_n = S_DONE;
      S_DONE: if (out_ready) state_n = accept ? entry_state : S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // operand capture, iteration and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= op;
      sa_q    <= sa;
      sb_q    <= sb;
      mag_a_q <= mag_a;
      mag_b_q <= mag_b;
      acc_hi  <= '0;
      acc_lo  <= is_mul ? mag_b : mag_a;
      cnt     <= SHW'(XLEN-1);
      if (direct) result <= direct_res;
    end else if (!flush && (state == S_MUL)) begin
      acc_hi <= mul_hi_n;
      acc_lo <= mul_lo_n;
      if (cnt != '0) cnt <= cnt - SHW'(1);
      else           result <= mul_res;
    end else if (!flush && (state == S_DIV)) begin
      acc_hi <= div_hi_n;
      acc_lo <= div_lo_n;
      if (cnt != '0) cnt <= cnt - SHW'(1);
      else           result <= div_res;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - self-checking bench for alu_mdu_seq against a behavioural model
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
    string       tag;
  } vec_t;
  vec_t vq[$];

`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [4:0] MID_OP = 5'd15;
`else
  localparam int MUL_LAT = 33;
  localparam logic [4:0] MID_OP = 5'd10;
`endif

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_i),
    .a         (a_i),
    .b         (b_i),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV-M semantics from plain wide arithmetic
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sp, sa;
    logic [63:0]        ux, uy, up;
    int                 xi, yi;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    xi = x;
    yi = y;
    case (o)
      5'd1:  return x - y;
      5'd2:  return x << y[4:0];
      5'd3:  return (xi < yi) ? 32'd1 : 32'd0;
      5'd4:  return (x < y) ? 32'd1 : 32'd0;
      5'd5:  return x ^ y;
      5'd6:  return x >> y[4:0];
      5'd7:  begin sa = sx >>> y[4:0]; return sa[31:0]; end
      5'd8:  return x | y;
      5'd9:  return x & y;
      5'd10: begin up = ux * uy; return up[31:0]; end
      5'd11: begin sp = sx * sy; return sp[63:32]; end
      5'd12: begin sp = sx * $signed(uy); return sp[63:32]; end
      5'd13: begin up = ux * uy; return up[63:32]; end
      5'd14: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return xi / yi;
      end
      5'd15: return (y == 0) ? 32'hFFFFFFFF : x / y;
      5'd16: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        return xi % yi;
      end
      5'd17: return (y == 0) ? x : x % y;
      default: return x + y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o >= 5'd10 && o <= 5'd13) return MUL_LAT;
    if (o >= 5'd14 && o <= 5'd17) begin
      if (y == 0) return 1;
      if ((o == 5'd14 || o == 5'd16) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // issue one op with out_ready high; latency counts edges from (and including) the accept edge
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat, output int bcnt);
    op_i = o; a_i = x; b_i = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e);
    logic [31:0] r;
    int lat, bc, el;
    el = exp_lat(o, x, y);
    run_op(o, x, y, r, lat, bc);
    check($sformatf("%s_res", tag), r, e);
    check($sformatf("%s_lat", tag), lat, el);
    check($sformatf("%s_busy", tag), bc, (el > 1) ? el - 1 : 0);
  endtask

  initial begin
    logic [31:0] x, y, r;
    logic [4:0]  o;
    int          lat, bc;
    bit          seen;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    vq.push_back('{5'd0,  32'd7,        32'd5,        32'd12,       "add"});
    vq.push_back('{5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, "sub"});
    vq.push_back('{5'd7,  32'h80000000, 32'd4,        32'hF8000000, "sra"});
    vq.push_back('{5'd6,  32'h80000000, 32'd4,        32'h08000000, "srl"});
    vq.push_back('{5'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        "slt"});
    vq.push_back('{5'd4,  32'hFFFFFFFF, 32'd1,        32'd0,        "sltu"});
    vq.push_back('{5'd2,  32'h00000003, 32'h00000024, 32'h00000030, "sll_lowbits"});
    vq.push_back('{5'd25, 32'd40,       32'd2,        32'd42,       "op25_add"});
    vq.push_back('{5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        "mulh"});
    vq.push_back('{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu"});
    vq.push_back('{5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        "mul"});
    vq.push_back('{5'd12, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu"});
    vq.push_back('{5'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div"});
    vq.push_back('{5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem"});
    vq.push_back('{5'd15, 32'd100,      32'd7,        32'd14,       "divu"});
    vq.push_back('{5'd17, 32'd100,      32'd7,        32'd2,        "remu"});
    vq.push_back('{5'd14, 32'd9,        32'd0,        32'hFFFFFFFF, "div0"});
    vq.push_back('{5'd16, 32'd9,        32'd0,        32'd9,        "rem0"});
    vq.push_back('{5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"});
    vq.push_back('{5'd16, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_ovf"});
    foreach (vq[i]) do_op(vq[i].tag, vq[i].o, vq[i].x, vq[i].y, vq[i].e);

    for (int i = 0; i < 60; i++) begin
      o = 5'($urandom_range(0, 31));
      x = pick();
      y = pick();
      do_op($sformatf("rnd%0d_op%0d", i, o), o, x, y, model(o, x, y));
    end

    // backpressure: result held and no new accept until out_ready
    out_ready = 1'b0;
    op_i = 5'd0; a_i = 32'd3; b_i = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_result%0d", i), result, 32'd7);
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    op_i = 5'd0; a_i = 32'd1; b_i = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", result, 32'd2);
    @(posedge clk); #1;
    check("bp_drained", 32'(out_valid), 32'd0);

    // flush ten cycles into a divide
    op_i = 5'd15; a_i = 32'd100; b_i = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);

    // flush beats a same-cycle accept
    op_i = 5'd0; a_i = 32'd1; b_i = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_prio_valid", 32'(out_valid), 32'd0);

    // async reset in the middle of an iterative op
    run_op(5'd0, 32'd1, 32'd1, r, lat, bc);
    check("pre_reset_result", r, 32'd2);
    op_i = MID_OP; a_i = 32'd3; b_i = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_result", result, 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_valid", 32'(out_valid), 32'd0);
    do_op("post_reset_add", 5'd0, 32'd20, 32'd22, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised, handshaked integer execution unit for the next core generation.
- Covers the base ALU op set (ADD..AND): XLEN-wide, registered output, corrected arithmetic SRA.
- Adds an iterative RV-M multiply/divide engine behind the same valid/ready interface.
- Sits in EX between operand mux and writeback; decode holds the op until in_ready.

Parameters:
- XLEN, 32, operand/result width (>=8, power of two)
- SHW, $clog2(XLEN), shift-amount bits taken from b

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  op/operands valid
- in_ready  out  1  unit can accept an op this cycle
- op  in  5  operation code (see Behaviour)
- a  in  XLEN  operand A
- b  in  XLEN  operand B
- flush  in  1  synchronous abort of in-flight op
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- busy  out  1  multi-cycle op in progress

Behaviour:
- Reset: while rst_n low (async), state=IDLE; out_valid=0, result=0, busy=0, counter=0, internal accumulators=0. in_ready=1 after reset.
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA (arithmetic, sign-fill), 8 OR, 9 AND
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18-31 execute as ADD.
- Shifts use b[SHW-1:0] only. SLT/SLTU return 1 or 0, zero-extended.
- Accept = in_valid & in_ready, sampled at rising edge; a, b, op latched.
- in_ready = (state==IDLE) | (state==DONE & out_ready): back-to-back issue when the result is consumed.
- States and transitions:
  - IDLE: base op -> DONE, result written at the accept edge (latency 1). Mul op -> MUL. Div op -> DIV, except the special cases below, which go straight to DONE.
  - MUL: shift-add on |a|,|b| magnitudes per signedness, one bit per cycle, XLEN cycles. Sign-correct the 2*XLEN product, select low half (MUL) or high half (MULH*) -> DONE. out_valid rises XLEN+1 cycles after the accept edge.
  - DIV: restoring division on magnitudes, XLEN cycles. Quotient sign = sa^sb; remainder sign = sign of dividend -> DONE. Same latency as MUL.
  - DONE: out_valid=1; result stable until out_ready. On out_ready: return to IDLE, or go to the next op's state if a new accept occurs in the same cycle.
- Division special cases (latency 1):
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (a==MIN, b==-1): DIV -> MIN; REM -> 0.
- busy = state in {MUL, DIV}.
- out_valid is never asserted in IDLE/MUL/DIV.
- flush: synchronous. Forces IDLE, out_valid=0 and drops any pending result. flush has priority over acceptance in the same cycle (no op accepted).
- Async reset mid-operation: abandons the op immediately; no partial result is ever presented.
- Counter counts XLEN-1 down to 0. Exit from MUL/DIV happens on the counter==0 cycle; no wrap.

Optional Feature:
- Macro ALU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU computed with a single combinational XLEN x XLEN multiply, latency 1 like base ops; MUL state unused, busy never set by multiplies.
- Undefined: iterative XLEN-cycle multiplier as above. Divide is iterative in both builds.

Test Plan:
- XLEN=32, out_ready=1: ADD a=7,b=5 -> 12; SUB 5-7 -> 0xFFFFFFFE; SRA 0x80000000>>4 -> 0xF8000000; SRL same -> 0x08000000; SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0; each out_valid exactly 1 cycle after accept.
- MULH a=0xFFFFFFFF,b=0xFFFFFFFF -> 0; MULHU -> 0xFFFFFFFE; MUL -> 1; MULHSU a=-1,b=2 -> 0xFFFFFFFF; out_valid at cycle 33 (iterative) / cycle 1 (ALU_FAST_MUL_EN).
- DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2; busy high for 32 cycles.
- DIV by 0 (a=9) -> 0xFFFFFFFF, REM -> 9; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all latency 1.
- Backpressure: out_ready=0 for 5 cycles after a result -> result held, in_ready=0. Raise out_ready with new in_valid ADD 1+1 -> accepted same cycle, next result 2.
- flush 10 cycles into DIVU -> out_valid stays 0, in_ready=1 next cycle. rst_n low mid-MUL -> all outputs 0 asynchronously.
